// File: rtl/apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// apu_frame_sequencer
//
// Frame sequencer for the APU. Counts CPU cycles and emits quarter-frame
// (envelope / linear counter) and half-frame (length counter / sweep) pulses
// in either the 4-step or the 5-step sequence. In 4-step mode it also raises
// the frame IRQ at the end of the sequence. A $4017 write selects the mode and
// IRQ inhibit, then restarts the sequence a few CPU cycles later.
//
// Ports
//   clk_in             : system clock (single clock domain)
//   rst_in             : synchronous, active-high reset
//   cpu_cycle_pulse_in : one-clk strobe per CPU cycle
//   wr_in              : $4017 write strobe, one clk wide
//   d_in[7:0]          : $4017 data; [7] = mode (1 = 5-step), [6] = IRQ inhibit
//   irq_clr_in         : $4015 read strobe, clears the frame IRQ flag
//   eg_pulse_out       : quarter-frame pulse, one clk wide
//   lc_pulse_out       : half-frame pulse, one clk wide
//   irq_out            : frame IRQ flag level
//   mode_out           : currently latched sequencer mode
// -----------------------------------------------------------------------------
module apu_frame_sequencer #(
    parameter int unsigned RESET_DELAY = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cpu_cycle_pulse_in,
    input  logic       wr_in,
    input  logic [7:0] d_in,
    input  logic       irq_clr_in,
    output logic       eg_pulse_out,
    output logic       lc_pulse_out,
    output logic       irq_out,
    output logic       mode_out
);

    localparam logic [15:0] CNT_STEP1     = 16'd7456;
    localparam logic [15:0] CNT_STEP2     = 16'd14912;
    localparam logic [15:0] CNT_STEP3     = 16'd22370;
    localparam logic [15:0] CNT_4STEP_END = 16'd29829;
    localparam logic [15:0] CNT_5STEP_END = 16'd37281;
    localparam logic [2:0]  DELAY_LOAD    = 3'(RESET_DELAY);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e      state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [2:0]  dly_q,     dly_d;
    logic        mode_q,    mode_d;
    logic        inhibit_q, inhibit_d;
    logic        irq_q,     irq_d;
    logic        eg_q,      eg_d;
    logic        lc_q,      lc_d;

    logic        quarter_s;
    logic        half_s;
    logic        irq_set_s;
    logic        wrap_s;
    logic        restart_s;

    // Only the two top data bits carry meaning for $4017.
    logic        unused_d_bits_s;
    assign unused_d_bits_s = ^d_in[5:0];

    // Decode sequence events from the current count on a CPU cycle.
    always_comb begin
        quarter_s = 1'b0;
        half_s    = 1'b0;
        irq_set_s = 1'b0;
        wrap_s    = 1'b0;
        if (cpu_cycle_pulse_in) begin
            case (cnt_q)
                CNT_STEP1: begin
                    quarter_s = 1'b1;
                end
                CNT_STEP2: begin
                    quarter_s = 1'b1;
                    half_s    = 1'b1;
                end
                CNT_STEP3: begin
                    quarter_s = 1'b1;
                end
                CNT_4STEP_END: begin
                    if (!mode_q) begin
                        quarter_s = 1'b1;
                        half_s    = 1'b1;
                        irq_set_s = 1'b1;
                        wrap_s    = 1'b1;
                    end else begin
                        wrap_s    = 1'b0;
                    end
                end
                CNT_5STEP_END: begin
                    if (mode_q) begin
                        quarter_s = 1'b1;
                        half_s    = 1'b1;
                        wrap_s    = 1'b1;
                    end else begin
                        wrap_s    = 1'b0;
                    end
                end
                default: begin
                    wrap_s = 1'b0;
                end
            endcase
        end else begin
            wrap_s = 1'b0;
        end
    end

    // RUN/PEND state machine: a write (re)loads the restart delay, CPU cycles
    // in PEND count it down, and the 1 -> 0 step fires the restart.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        mode_d    = mode_q;
        inhibit_d = inhibit_q;
        restart_s = 1'b0;
        if (wr_in) begin
            state_d   = ST_PEND;
            dly_d     = DELAY_LOAD;
            mode_d    = d_in[7];
            inhibit_d = d_in[6];
        end else if ((state_q == ST_PEND) && cpu_cycle_pulse_in) begin
            // A zero delay can only come from an out-of-range parameter;
            // treat it like 1 so PEND can never get stuck.
            if (dly_q <= 3'd1) begin
                restart_s = 1'b1;
                state_d   = ST_RUN;
                dly_d     = 3'd0;
            end else begin
                dly_d     = dly_q - 3'd1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Cycle counter, output pulses and IRQ flag next state.
    always_comb begin
        cnt_d = cnt_q;
        eg_d  = 1'b0;
        lc_d  = 1'b0;
        irq_d = irq_q;

        // A restart replaces whatever was decoded in the same cycle.
        if (restart_s) begin
            cnt_d = 16'd0;
            eg_d  = mode_q;
            lc_d  = mode_q;
        end else if (cpu_cycle_pulse_in) begin
            cnt_d = wrap_s ? 16'd0 : (cnt_q + 16'd1);
            eg_d  = quarter_s;
            lc_d  = half_s;
        end else begin
            cnt_d = cnt_q;
        end

        // Read-clear loses to a simultaneous set; an inhibiting write clears last.
        if (irq_clr_in) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
        if (irq_set_s && !restart_s && !inhibit_q) begin
            irq_d = 1'b1;
        end else begin
            irq_d = irq_d;
        end
        if (wr_in && d_in[6]) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_d;
        end
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_RUN;
            cnt_q     <= 16'd0;
            dly_q     <= 3'd0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            eg_q      <= 1'b0;
            lc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
            eg_q      <= eg_d;
            lc_q      <= lc_d;
        end
    end

    assign eg_pulse_out = eg_q;
    assign lc_pulse_out = lc_q;
    assign irq_out      = irq_q;
    assign mode_out     = mode_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apu_frame_sequencer
//
// Directed bench for apu_frame_sequencer with RESET_DELAY = 3. A CPU-cycle
// pulse is driven on every clk during the long runs. Pulse positions are
// given by the count value decoded on that pulse: the pulse that sees count N
// produces its outputs one clk later.
// -----------------------------------------------------------------------------
module tb_apu_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       cpu;
    logic       wr;
    logic [7:0] din;
    logic       clr;
    logic       eg;
    logic       lc;
    logic       irq;
    logic       mode;

    int checks;
    int errors;

    apu_frame_sequencer #(
        .RESET_DELAY(3)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .cpu_cycle_pulse_in(cpu),
        .wr_in             (wr),
        .d_in              (din),
        .irq_clr_in        (irq_clr_dummy_unused_guard(clr)),
        .eg_pulse_out      (eg),
        .lc_pulse_out      (lc),
        .irq_out           (irq),
        .mode_out          (mode)
    );

    function automatic logic irq_clr_dummy_unused_guard(input logic v);
        return v;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one clk of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic p, input logic w, input logic [7:0] d, input logic c);
        cpu = p;
        wr  = w;
        din = d;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b1, 1'b1, 8'hC0, 1'b1);
        step(1'b1, 1'b1, 8'hC0, 1'b1);
        checks++; if (eg !== 1'b0)   begin errors++; $display("FAIL reset_eg got %b want 0", eg); end
        checks++; if (lc !== 1'b0)   begin errors++; $display("FAIL reset_lc got %b want 0", lc); end
        checks++; if (irq !== 1'b0)  begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", mode); end
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (mode !== 1'b0) begin errors++; $display("FAIL reset_release_mode got %b want 0", mode); end
        checks++; if (irq !== 1'b0)  begin errors++; $display("FAIL reset_release_irq got %b want 0", irq); end
    endtask

    // Reset during PEND in 5-step mode: no restart pulses, mode back to 0,
    // then a clean 4-step count from zero up to count 7456.
    task automatic test_reset_mid_pend;
        step(1'b0, 1'b1, 8'h80, 1'b0);
        checks++; if (mode !== 1'b1) begin errors++; $display("FAIL pend_mode_latch got %b want 1", mode); end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checks++; if (mode !== 1'b0) begin errors++; $display("FAIL pend_reset_mode got %b want 0", mode); end
        for (int i = 1; i <= 7456; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            checks++; if (eg !== 1'b0) begin errors++; $display("FAIL pend_reset_eg pulse=%0d got %b want 0", i, eg); end
            checks++; if (lc !== 1'b0) begin errors++; $display("FAIL pend_reset_lc pulse=%0d got %b want 0", i, lc); end
        end
    endtask

    // Continue the 4-step sequence to count 29829; irq_clr coincides with the set.
    task automatic test_four_step;
        logic exp_eg;
        logic exp_lc;
        logic exp_irq;
        for (int n = 7456; n <= 29829; n++) begin
            step(1'b1, 1'b0, 8'h00, (n == 29829));
            exp_eg  = (n == 7456) || (n == 14912) || (n == 22370) || (n == 29829);
            exp_lc  = (n == 14912) || (n == 29829);
            exp_irq = (n == 29829);
            checks++; if (eg !== exp_eg)   begin errors++; $display("FAIL four_eg count=%0d got %b want %b", n, eg, exp_eg); end
            checks++; if (lc !== exp_lc)   begin errors++; $display("FAIL four_lc count=%0d got %b want %b", n, lc, exp_lc); end
            checks++; if (irq !== exp_irq) begin errors++; $display("FAIL four_irq count=%0d got %b want %b", n, irq, exp_irq); end
        end
        // Write without inhibit leaves a raised IRQ alone.
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL write00_keeps_irq got %b want 1", irq); end
        checks++; if (eg !== 1'b0)  begin errors++; $display("FAIL four_eg_single got %b want 0", eg); end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    // Restart in 4-step mode (no pulses), count up, then pass count 29829 with
    // inhibit set by a 0x40 write issued just before it.
    task automatic test_inhibit;
        logic exp_eg;
        logic exp_lc;
        int   n;
        for (int j = 1; j <= 29832; j++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            n = j - 4;
            exp_eg = (n == 7456) || (n == 14912) || (n == 22370);
            exp_lc = (n == 14912);
            checks++; if (eg !== exp_eg) begin errors++; $display("FAIL inh_eg pulse=%0d got %b want %b", j, eg, exp_eg); end
            checks++; if (lc !== exp_lc) begin errors++; $display("FAIL inh_lc pulse=%0d got %b want %b", j, lc, exp_lc); end
            checks++; if (irq !== 1'b0)  begin errors++; $display("FAIL inh_irq_early pulse=%0d got %b want 0", j, irq); end
        end
        step(1'b0, 1'b1, 8'h40, 1'b0);
        checks++; if (mode !== 1'b0) begin errors++; $display("FAIL inh_mode got %b want 0", mode); end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (eg !== 1'b1)  begin errors++; $display("FAIL inh_end_eg got %b want 1", eg); end
        checks++; if (lc !== 1'b1)  begin errors++; $display("FAIL inh_end_lc got %b want 1", lc); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL inh_end_irq got %b want 0", irq); end
        for (int j = 1; j <= 2; j++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            checks++; if (eg !== 1'b0) begin errors++; $display("FAIL inh_restart_eg pulse=%0d got %b want 0", j, eg); end
            checks++; if (lc !== 1'b0) begin errors++; $display("FAIL inh_restart_lc pulse=%0d got %b want 0", j, lc); end
        end
    endtask

    // 5-step write, re-write two pulses into PEND, restart 3 pulses after the
    // second write, then the full 5-step sequence with no IRQ.
    task automatic test_five_step;
        logic exp_eg;
        logic exp_lc;
        step(1'b0, 1'b1, 8'h80, 1'b0);
        checks++; if (mode !== 1'b1) begin errors++; $display("FAIL five_mode got %b want 1", mode); end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b0);
        for (int j = 1; j <= 2; j++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            checks++; if (eg !== 1'b0) begin errors++; $display("FAIL rewrite_early_eg pulse=%0d got %b want 0", j, eg); end
            checks++; if (lc !== 1'b0) begin errors++; $display("FAIL rewrite_early_lc pulse=%0d got %b want 0", j, lc); end
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (eg !== 1'b1) begin errors++; $display("FAIL restart_eg got %b want 1", eg); end
        checks++; if (lc !== 1'b1) begin errors++; $display("FAIL restart_lc got %b want 1", lc); end
        for (int n = 0; n <= 37281; n++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            exp_eg = (n == 7456) || (n == 14912) || (n == 22370) || (n == 37281);
            exp_lc = (n == 14912) || (n == 37281);
            checks++; if (eg !== exp_eg) begin errors++; $display("FAIL five_eg count=%0d got %b want %b", n, eg, exp_eg); end
            checks++; if (lc !== exp_lc) begin errors++; $display("FAIL five_lc count=%0d got %b want %b", n, lc, exp_lc); end
            checks++; if (irq !== 1'b0)  begin errors++; $display("FAIL five_irq count=%0d got %b want 0", n, irq); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        cpu    = 1'b0;
        wr     = 1'b0;
        din    = 8'h00;
        clr    = 1'b0;
        test_reset();
        test_reset_mid_pend();
        test_four_step();
        test_inhibit();
        test_five_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
